// File: rtl/castling_move_sequencer.sv
// ----------------------------------------------------------------------------
// castling_move_sequencer
//
// Routes castling requests through the shared combinational castling checker.
// This block owns the live board (twelve 64-bit piece bitboards) and the four
// castling-rights flags. It registers a request onto the checker inputs, lets
// the checker output settle, and then either commits the rearranged board or
// rejects the move. Other moves and new games reach the board via board_load.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   req_valid/ready      castling request handshake (ready only in IDLE)
//   req_old_*/new_*      king source/destination file and rank
//   req_is_white         side to castle
//   board_load/board_in  overwrite the board (IDLE only; wins over a request)
//   rights_load/in       overwrite rights {BQ,BK,WQ,WK} (IDLE only)
//   rights_clear         per-bit clear strobe, honoured in every state
//   chk_*  (out)         registered request and live board to the checker
//   chk_valid            checker verdict
//   chk_new_bitboards    checker's rearranged board
//   board_q, rights_q    live board and castling rights
//   done                 one-cycle pulse per accepted request
//   accepted, reason     outcome, valid with done (0 ok, 1 no rights,
//                        2 checker rejected); held until the next done
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | ready for a request; board/rights loads honoured
//   S_EVAL   | checker inputs stable, waiting SETTLE_CYCLES for result
//   S_COMMIT | write checker board, drop both rights of the side
//   S_REJECT | report rejection, board and rights untouched
// ----------------------------------------------------------------------------
module castling_move_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int BB_W          = 768
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_old_file,
    input  logic [2:0]      req_old_rank,
    input  logic [2:0]      req_new_file,
    input  logic [2:0]      req_new_rank,
    input  logic            req_is_white,

    input  logic            board_load,
    input  logic [BB_W-1:0] board_in,
    input  logic            rights_load,
    input  logic [3:0]      rights_in,
    input  logic [3:0]      rights_clear,

    output logic [2:0]      chk_old_file,
    output logic [2:0]      chk_old_rank,
    output logic [2:0]      chk_new_file,
    output logic [2:0]      chk_new_rank,
    output logic            chk_is_white,
    output logic [BB_W-1:0] chk_bitboards,
    input  logic            chk_valid,
    input  logic [BB_W-1:0] chk_new_bitboards,

    output logic [BB_W-1:0] board_q,
    output logic [3:0]      rights_q,
    output logic            done,
    output logic            accepted,
    output logic [1:0]      reason
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EVAL   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_REJECT = 2'd3;

    localparam logic [1:0] RSN_OK      = 2'd0;
    localparam logic [1:0] RSN_RIGHTS  = 2'd1;
    localparam logic [1:0] RSN_CHECKER = 2'd2;

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]      state;
    logic [CNT_W-1:0] settle_cnt;
    logic [BB_W-1:0] new_bb_q;
    logic [1:0]      rej_reason;

    logic            is_idle;
    logic            req_short;
    logic [1:0]      right_idx;
    logic            right_ok;
    logic [3:0]      rights_base;
    logic [3:0]      side_clear;
    logic [3:0]      rights_next;

    // The checker always looks at the live board; load gating keeps it
    // stable for the whole evaluation window.
    assign chk_bitboards = board_q;

    always_comb begin
        is_idle   = (state == S_IDLE);
        // A same-cycle board_load takes the IDLE slot, so the request waits.
        req_ready = is_idle & ~board_load;

        // Rights bit index: {BQ,BK,WQ,WK} -> black adds 2, queen side adds 1.
        req_short = (req_new_file > req_old_file);
        right_idx = {~req_is_white, ~req_short};
        right_ok  = rights_q[right_idx];

        rights_base = (is_idle && rights_load) ? rights_in : rights_q;

        side_clear = 4'b0000;
        if (state == S_COMMIT) begin
            side_clear = chk_is_white ? 4'b0011 : 4'b1100;
        end

        // External clears apply on top of loads and commits, in any state.
        rights_next = rights_base & ~side_clear & ~rights_clear;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            new_bb_q     <= '0;
            rej_reason   <= RSN_OK;
            board_q      <= '0;
            rights_q     <= 4'b1111;
            chk_old_file <= '0;
            chk_old_rank <= '0;
            chk_new_file <= '0;
            chk_new_rank <= '0;
            chk_is_white <= 1'b0;
            done         <= 1'b0;
            accepted     <= 1'b0;
            reason       <= RSN_OK;
        end else begin
            done     <= 1'b0;
            rights_q <= rights_next;

            case (state)
                S_IDLE: begin
                    if (board_load) begin
                        board_q <= board_in;
                    end else if (req_valid) begin
                        chk_old_file <= req_old_file;
                        chk_old_rank <= req_old_rank;
                        chk_new_file <= req_new_file;
                        chk_new_rank <= req_new_rank;
                        chk_is_white <= req_is_white;
                        if (right_ok) begin
                            settle_cnt <= CNT_LOAD;
                            state      <= S_EVAL;
                        end else begin
                            // No right for this side/wing: skip the checker.
                            rej_reason <= RSN_RIGHTS;
                            state      <= S_REJECT;
                        end
                    end
                end

                S_EVAL: begin
                    if (settle_cnt == '0) begin
                        new_bb_q <= chk_new_bitboards;
                        if (chk_valid) begin
                            state <= S_COMMIT;
                        end else begin
                            rej_reason <= RSN_CHECKER;
                            state      <= S_REJECT;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end

                S_COMMIT: begin
                    board_q  <= new_bb_q;
                    done     <= 1'b1;
                    accepted <= 1'b1;
                    reason   <= RSN_OK;
                    state    <= S_IDLE;
                end

                S_REJECT: begin
                    done     <= 1'b1;
                    accepted <= 1'b0;
                    reason   <= rej_reason;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_castling_move_sequencer.sv
// ----------------------------------------------------------------------------
// tb_castling_move_sequencer
//
// Directed bench for castling_move_sequencer. A small behavioural castling
// checker closes the loop on the chk_* interface. A table of castling cases is
// applied in a loop; hand-written sequences cover load/request collisions,
// rights clears during evaluation and reset in the middle of a request.
// Latency is counted in rising edges, including the edge that accepts the
// request.
// ----------------------------------------------------------------------------
module tb_castling_move_sequencer;

    localparam int BB_W = 768;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_old_file, req_old_rank, req_new_file, req_new_rank;
    logic            req_is_white;
    logic            board_load;
    logic [BB_W-1:0] board_in;
    logic            rights_load;
    logic [3:0]      rights_in;
    logic [3:0]      rights_clear;
    logic [2:0]      chk_old_file, chk_old_rank, chk_new_file, chk_new_rank;
    logic            chk_is_white;
    logic [BB_W-1:0] chk_bitboards;
    logic            chk_valid;
    logic [BB_W-1:0] chk_new_bitboards;
    logic [BB_W-1:0] board_q;
    logic [3:0]      rights_q;
    logic            done;
    logic            accepted;
    logic [1:0]      reason;

    int errors = 0;
    int checks = 0;

    castling_move_sequencer #(.SETTLE_CYCLES(2), .BB_W(BB_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_old_file      (req_old_file),
        .req_old_rank      (req_old_rank),
        .req_new_file      (req_new_file),
        .req_new_rank      (req_new_rank),
        .req_is_white      (req_is_white),
        .board_load        (board_load),
        .board_in          (board_in),
        .rights_load       (rights_load),
        .rights_in         (rights_in),
        .rights_clear      (rights_clear),
        .chk_old_file      (chk_old_file),
        .chk_old_rank      (chk_old_rank),
        .chk_new_file      (chk_new_file),
        .chk_new_rank      (chk_new_rank),
        .chk_is_white      (chk_is_white),
        .chk_bitboards     (chk_bitboards),
        .chk_valid         (chk_valid),
        .chk_new_bitboards (chk_new_bitboards),
        .board_q           (board_q),
        .rights_q          (rights_q),
        .done              (done),
        .accepted          (accepted),
        .reason            (reason)
    );

    always #5 clk = ~clk;

    // Behavioural checker: king on e-file, own rook in the corner, path empty.
    // Pieces: 0..5 black P N B R Q K, 6..11 white P N B R Q K; square = rank*8+file.
    logic            m_valid;
    logic [BB_W-1:0] m_new;
    always_comb begin
        logic [63:0] occ;
        logic [63:0] path;
        logic        sh;
        int          kb, rb, base, ksq, nksq, rsq, nrsq;
        occ = '0;
        for (int p = 0; p < 12; p++) occ |= chk_bitboards[p*64 +: 64];
        sh   = chk_new_file > chk_old_file;
        kb   = chk_is_white ? 11 : 5;
        rb   = chk_is_white ? 9 : 3;
        base = int'(chk_old_rank) * 8;
        ksq  = base + 4;
        nksq = base + int'(chk_new_file);
        rsq  = base + (sh ? 7 : 0);
        nrsq = base + (sh ? 5 : 3);
        path = sh ? (64'h60 << base) : (64'h0E << base);
        m_valid = (chk_old_file == 3'd4) && (chk_new_rank == chk_old_rank) &&
                  (chk_new_file == 3'd6 || chk_new_file == 3'd2) &&
                  chk_bitboards[kb*64 + ksq] && chk_bitboards[rb*64 + rsq] &&
                  ((occ & path) == 64'd0);
        m_new = chk_bitboards;
        m_new[kb*64 + ksq]  = 1'b0;
        m_new[kb*64 + nksq] = 1'b1;
        m_new[rb*64 + rsq]  = 1'b0;
        m_new[rb*64 + nrsq] = 1'b1;
    end
    assign chk_valid         = m_valid;
    assign chk_new_bitboards = m_new;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_board(input string name, input logic [BB_W-1:0] exp);
        checks++;
        if (board_q !== exp) begin
            errors++;
            $display("FAIL %s: board_q differs, got %h", name, board_q);
        end
    endtask

    function automatic logic [63:0] bb(input logic [BB_W-1:0] b, input int p);
        return b[p*64 +: 64];
    endfunction

    // Both kings on e, all four rooks home, optional single blocker.
    function automatic logic [BB_W-1:0] build_board(input logic blk_en, input int blk_piece, input int blk_sq);
        logic [BB_W-1:0] b;
        b = '0;
        b[11*64 +: 64] = 64'h0000_0000_0000_0010;
        b[9*64 +: 64]  = 64'h0000_0000_0000_0081;
        b[5*64 +: 64]  = 64'h1000_0000_0000_0000;
        b[3*64 +: 64]  = 64'h8100_0000_0000_0000;
        if (blk_en) b[blk_piece*64 + blk_sq] = 1'b1;
        return b;
    endfunction

    task automatic load_state(input logic [BB_W-1:0] b, input logic [3:0] r);
        @(negedge clk);
        board_load  = 1'b1;
        board_in    = b;
        rights_load = 1'b1;
        rights_in   = r;
        @(posedge clk);
        #1;
        board_load  = 1'b0;
        rights_load = 1'b0;
    endtask

    task automatic start_req(input logic w, input logic s);
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_white = w;
        req_old_file = 3'd4;
        req_new_file = s ? 3'd6 : 3'd2;
        req_old_rank = w ? 3'd0 : 3'd7;
        req_new_rank = w ? 3'd0 : 3'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Returns edges from acceptance (counted as 1) to done; 0 on timeout.
    task automatic run_req(input logic w, input logic s, output int lat);
        int n;
        start_req(w, s);
        n = 1;
        while (!done && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = done ? n : 0;
    endtask

    typedef struct {
        logic        is_white;
        logic        is_short;
        logic [3:0]  rights_init;
        logic        blk_en;
        int          blk_piece;
        int          blk_sq;
        int          exp_lat;
        logic        exp_acc;
        logic [1:0]  exp_reason;
        logic [3:0]  exp_rights;
        logic [63:0] exp_king;
        logic [63:0] exp_rook;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int              lat;
        int              n;
        logic            seen;
        logic [BB_W-1:0] b;
        logic [BB_W-1:0] saved;

        vecs[0] = '{1'b1, 1'b1, 4'b1111, 1'b0, 0, 0,  4, 1'b1, 2'd0, 4'b1100, 64'h40, 64'h21};
        vecs[1] = '{1'b1, 1'b0, 4'b1111, 1'b0, 0, 0,  4, 1'b1, 2'd0, 4'b1100, 64'h04, 64'h88};
        vecs[2] = '{1'b0, 1'b1, 4'b1111, 1'b0, 0, 0,  4, 1'b1, 2'd0, 4'b0011,
                    64'h4000_0000_0000_0000, 64'h2100_0000_0000_0000};
        vecs[3] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4, 59, 4, 1'b0, 2'd2, 4'b1111,
                    64'h1000_0000_0000_0000, 64'h8100_0000_0000_0000};
        vecs[4] = '{1'b1, 1'b1, 4'b1110, 1'b0, 0, 0,  2, 1'b0, 2'd1, 4'b1110, 64'h10, 64'h81};
        vecs[5] = '{1'b0, 1'b0, 4'b0111, 1'b0, 0, 0,  2, 1'b0, 2'd1, 4'b0111,
                    64'h1000_0000_0000_0000, 64'h8100_0000_0000_0000};
        vecs[6] = '{1'b1, 1'b0, 4'b1111, 1'b1, 7, 1,  4, 1'b0, 2'd2, 4'b1111, 64'h10, 64'h81};
        vecs[7] = '{1'b0, 1'b1, 4'b1011, 1'b0, 0, 0,  2, 1'b0, 2'd1, 4'b1011,
                    64'h1000_0000_0000_0000, 64'h8100_0000_0000_0000};

        rst = 1'b1;
        req_valid = 1'b0; req_is_white = 1'b0;
        req_old_file = '0; req_old_rank = '0; req_new_file = '0; req_new_rank = '0;
        board_load = 1'b0; board_in = '0;
        rights_load = 1'b0; rights_in = '0; rights_clear = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_board", 64'(board_q == '0), 64'd1);
        check("rst_rights", 64'(rights_q), 64'hF);
        check("rst_done", 64'(done), 64'd0);
        check("rst_accepted", 64'(accepted), 64'd0);
        check("rst_reason", 64'(reason), 64'd0);
        check("rst_chk_file", 64'(chk_new_file), 64'd0);

        // Spec scenario 1: lone wK e1 / wR h1, white short castle
        @(negedge clk);
        b = '0;
        b[11*64 +: 64] = 64'h10;
        b[9*64 +: 64]  = 64'h80;
        board_load = 1'b1;
        board_in   = b;
        @(posedge clk);
        #1;
        board_load = 1'b0;
        run_req(1'b1, 1'b1, lat);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_accepted", 64'(accepted), 64'd1);
        check("t1_reason", 64'(reason), 64'd0);
        check("t1_wk", bb(board_q, 11), 64'h40);
        check("t1_wr", bb(board_q, 9), 64'h20);
        check("t1_rights", 64'(rights_q), 64'hC);
        check("t1_chk_new_file", 64'(chk_new_file), 64'd6);
        @(posedge clk);
        #1;
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_acc_hold", 64'(accepted), 64'd1);

        // Spec scenario 2: repeat, rights already gone
        saved = board_q;
        run_req(1'b1, 1'b1, lat);
        check("t2_latency", 64'(lat), 64'd2);
        check("t2_accepted", 64'(accepted), 64'd0);
        check("t2_reason", 64'(reason), 64'd1);
        check_board("t2_board", saved);

        // Table of castling cases
        for (int i = 0; i < 8; i++) begin
            int kb, rb;
            kb = vecs[i].is_white ? 11 : 5;
            rb = vecs[i].is_white ? 9 : 3;
            load_state(build_board(vecs[i].blk_en, vecs[i].blk_piece, vecs[i].blk_sq),
                       vecs[i].rights_init);
            run_req(vecs[i].is_white, vecs[i].is_short, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_accepted", i), 64'(accepted), 64'(vecs[i].exp_acc));
            check($sformatf("v%0d_reason", i), 64'(reason), 64'(vecs[i].exp_reason));
            check($sformatf("v%0d_rights", i), 64'(rights_q), 64'(vecs[i].exp_rights));
            check($sformatf("v%0d_king", i), bb(board_q, kb), vecs[i].exp_king);
            check($sformatf("v%0d_rook", i), bb(board_q, rb), vecs[i].exp_rook);
        end

        // Spec scenario 4: board_load and req_valid in the same IDLE cycle
        b = build_board(1'b1, 0, 20);
        @(negedge clk);
        board_load   = 1'b1;
        board_in     = b;
        req_valid    = 1'b1;
        req_is_white = 1'b1;
        req_old_file = 3'd4; req_new_file = 3'd6;
        req_old_rank = 3'd0; req_new_rank = 3'd0;
        #1;
        check("t4_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        board_load = 1'b0;
        req_valid  = 1'b0;
        check_board("t4_board", b);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("t4_no_done", 64'(seen), 64'd0);
        check("t4_idle", 64'(req_ready), 64'd1);

        // rights_load together with rights_clear, then a clear alone in IDLE
        @(negedge clk);
        rights_load  = 1'b1;
        rights_in    = 4'b1111;
        rights_clear = 4'b0010;
        @(posedge clk);
        #1;
        rights_load  = 1'b0;
        rights_clear = 4'b0100;
        @(posedge clk);
        #1;
        rights_clear = 4'b0000;
        check("rl_rc_rights", 64'(rights_q), 64'b1001);

        // Spec scenario 5: WK clear and an (ignored) board_load during EVAL
        load_state(build_board(1'b0, 0, 0), 4'b1111);
        start_req(1'b1, 1'b1);
        rights_clear = 4'b0001;
        board_load   = 1'b1;
        board_in     = '0;
        rights_load  = 1'b1;
        rights_in    = 4'b0000;
        @(posedge clk);
        #1;
        rights_clear = 4'b0000;
        board_load   = 1'b0;
        rights_load  = 1'b0;
        check("t5_rights_mid", 64'(rights_q), 64'b1110);
        n = 2;
        while (!done && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_latency", 64'(done ? n : 0), 64'd4);
        check("t5_accepted", 64'(accepted), 64'd1);
        check("t5_rights", 64'(rights_q), 64'b1100);
        check("t5_wk", bb(board_q, 11), 64'h40);
        check("t5_wr", bb(board_q, 9), 64'h21);

        // Spec scenario 6: reset while in EVAL
        load_state(build_board(1'b0, 0, 0), 4'b1111);
        start_req(1'b0, 1'b1);
        check("t6_in_eval", 64'(req_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_idle", 64'(req_ready), 64'd1);
        check("t6_board", 64'(board_q == '0), 64'd1);
        check("t6_rights", 64'(rights_q), 64'hF);
        seen = done;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("t6_no_done", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
